// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// default bit-period helper also used by the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_MIN_PERIOD = 3;

  function automatic logic [15:0] uart_default_period(input int clk_hz, input int baud);
    return 16'(clk_hz / baud - 1);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification, mid-bit LSB-first sampling,
// stop-bit check and a single valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_bit_period_i,
  input  logic [15:0] bit_period_i,
  input  logic        uart_rxd,
  output logic [7:0]  uart_rx_data,
  output logic        uart_rx_valid,
  input  logic        uart_rx_ready,
  output logic        uart_rx_busy,
  output logic        uart_rx_frame_err,
  output logic        uart_rx_overrun
);

  localparam logic [15:0] DEF_PERIOD = uart_default_period(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] MIN_PERIOD = 16'(UART_MIN_PERIOD);
  localparam logic [2:0]  LAST_BIT   = 3'(UART_DATA_BITS - 1);

  logic rxd_s, rxd_q;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (rxd_s)
  );

  uart_rx_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, bp_pend_q, bp_pend_d, bp_act_q, bp_act_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d, data_q, data_d;
  logic        valid_q, valid_d, busy_q, busy_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic        at_half, at_bound, load;

  assign at_half  = (cnt_q == (bp_act_q >> 1));
  assign at_bound = (cnt_q == bp_act_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (rxd_q && !rxd_s) state_d = RX_START;
      RX_START: if (at_half) state_d = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (at_bound && bit_idx_q == LAST_BIT) state_d = RX_STOP;
      RX_STOP:  if (at_bound) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    bp_pend_d = bp_pend_q;
    if (wr_bit_period_i)
      bp_pend_d = (bit_period_i < MIN_PERIOD) ? MIN_PERIOD : bit_period_i;
    // The active period only follows the pending one between frames.
    bp_act_d = (state_q == RX_IDLE) ? bp_pend_q : bp_act_q;

    cnt_d = (state_d != state_q || state_q == RX_IDLE || at_bound) ? 16'd0 : cnt_q + 16'd1;

    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    if (state_q == RX_START && state_d == RX_DATA)
      bit_idx_d = 3'd0;
    if (state_q == RX_DATA && at_bound) begin
      shreg_d   = {rxd_s, shreg_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    load    = (state_q == RX_STOP) && at_bound && rxd_s;
    ferr_d  = (state_q == RX_STOP) && at_bound && !rxd_s;
    data_d  = load ? shreg_q : data_q;
    valid_d = load || (valid_q && !uart_rx_ready);
    ovr_d   = load && valid_q && !uart_rx_ready;
    busy_d  = (state_d != RX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q     <= 1'b1;
      cnt_q     <= '0;
      bp_pend_q <= DEF_PERIOD;
      bp_act_q  <= DEF_PERIOD;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rxd_q     <= rxd_s;
      cnt_q     <= cnt_d;
      bp_pend_q <= bp_pend_d;
      bp_act_q  <= bp_act_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_busy      = busy_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are generated bit by bit,
// received bytes and pulses are collected by a monitor and checked against a queue model.
module tb_uart_rx;

  localparam int DEF_P = 50_000_000 / 115200;  // clocks per bit at reset rate (434)

  logic        clk = 1'b0, rst = 1'b1, wr = 1'b0, rxd = 1'b1, ready = 1'b0;
  logic [15:0] bp_in = '0;
  logic [7:0]  data;
  logic        valid, busy, ferr, ovr;

  uart_rx dut (
    .clk               (clk),
    .rst               (rst),
    .wr_bit_period_i   (wr),
    .bit_period_i      (bp_in),
    .uart_rxd          (rxd),
    .uart_rx_data      (data),
    .uart_rx_valid     (valid),
    .uart_rx_ready     (ready),
    .uart_rx_busy      (busy),
    .uart_rx_frame_err (ferr),
    .uart_rx_overrun   (ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_ferr = 0, n_ovr = 0, n_busy_rise = 0;
  logic busy_prev = 1'b0;
  byte unsigned rx_q[$];

  // Monitor: samples just after the falling edge, when inputs for the next edge are settled.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (valid && ready) rx_q.push_back(data);
      if (ferr) n_ferr++;
      if (ovr)  n_ovr++;
      if (busy && !busy_prev) n_busy_rise++;
    end
    busy_prev = busy;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_rx(input string name, input int exp);
    if (rx_q.size() == 0) chk(name, -1, exp);
    else chk(name, int'(rx_q.pop_front()), exp);
  endtask

  task automatic drive_bit(input logic v, input int p);
    rxd = v;
    repeat (p) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int p);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(b[i], p);
    drive_bit(stop, p);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_period(input int v);
    wr = 1'b1;
    bp_in = 16'(v);
    @(negedge clk);
    wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int eff_p(input int w);
    return ((w < 3) ? 3 : w) + 1;
  endfunction

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         wp;        // value written to bit_period_i
    int         exp_hs;    // handshakes expected
    logic [7:0] exp_data;
    int         exp_err;   // frame_err pulses expected
  } vec_t;

  vec_t vt[7];

  initial begin
    int e0, o0, b0, cur_w, exp_err;
    byte unsigned exp_q[$];

    vt[0] = '{8'h5A, 1'b1, 19, 1, 8'h5A, 0};
    vt[1] = '{8'h3C, 1'b0, 19, 0, 8'h00, 1};
    vt[2] = '{8'h80, 1'b1, 19, 1, 8'h80, 0};
    vt[3] = '{8'h01, 1'b1, 3,  1, 8'h01, 0};
    vt[4] = '{8'hC6, 1'b1, 0,  1, 8'hC6, 0};
    vt[5] = '{8'h00, 1'b1, 1,  1, 8'h00, 0};
    vt[6] = '{8'hFF, 1'b0, 7,  0, 8'h00, 1};

    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_data",  int'(data),  0);
    chk("rst_ferr",  int'(ferr),  0);
    chk("rst_ovr",   int'(ovr),   0);
    rst = 1'b0;
    ready = 1'b1;
    idle(4);

    // Default rate single frame
    e0 = n_ferr;
    send(8'hA5, 1'b1, DEF_P);
    idle(3);
    chk_rx("def_a5", 8'hA5);
    chk("def_ferr", n_ferr - e0, 0);

    // Short low glitch rejected at half bit
    e0 = n_ferr;
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_busy_mid", int'(busy), 1);
    repeat (30) @(negedge clk);
    chk("glitch_busy_end", int'(busy), 0);
    chk("glitch_no_valid", rx_q.size(), 0);
    chk("glitch_ferr", n_ferr - e0, 0);

    // Table of single frames
    cur_w = -1;
    foreach (vt[i]) begin
      if (vt[i].wp != cur_w) begin
        set_period(vt[i].wp);
        cur_w = vt[i].wp;
      end
      e0 = n_ferr; o0 = n_ovr;
      rx_q.delete();
      send(vt[i].b, vt[i].stop, eff_p(vt[i].wp));
      idle(3);
      chk($sformatf("vec%0d_hs", i), rx_q.size(), vt[i].exp_hs);
      if (vt[i].exp_hs > 0) chk_rx($sformatf("vec%0d_data", i), vt[i].exp_data);
      chk($sformatf("vec%0d_ferr", i), n_ferr - e0, vt[i].exp_err);
      chk($sformatf("vec%0d_ovr", i), n_ovr - o0, 0);
    end

    // Back-to-back frames with no idle between them
    set_period(19);
    o0 = n_ovr;
    rx_q.delete();
    send(8'h5A, 1'b1, 20);
    send(8'hFF, 1'b1, 20);
    idle(3);
    chk("b2b_cnt", rx_q.size(), 2);
    chk_rx("b2b_first", 8'h5A);
    chk_rx("b2b_second", 8'hFF);
    chk("b2b_ovr", n_ovr - o0, 0);

    // Bad stop bit, line then held low: one error, no retrigger
    e0 = n_ferr; b0 = n_busy_rise;
    send(8'h3C, 1'b0, 20);
    rxd = 1'b0;
    repeat (2000) @(negedge clk);
    chk("ferr_pulses", n_ferr - e0, 1);
    chk("ferr_valid", int'(valid), 0);
    chk("ferr_busy", int'(busy), 0);
    chk("ferr_no_retrigger", n_busy_rise - b0, 1);
    idle(3);

    // Overrun: consumer not ready
    ready = 1'b0;
    o0 = n_ovr;
    send(8'h11, 1'b1, 20);
    idle(3);
    chk("ovr_first_data", int'(data), 8'h11);
    send(8'h22, 1'b1, 20);
    idle(3);
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_data", int'(data), 8'h22);
    chk("ovr_valid", int'(valid), 1);

    // Reset in the middle of data bit 3 of 0x42
    drive_bit(1'b0, 20);
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 20);
    drive_bit(1'b0, 20);
    drive_bit(1'b0, 10);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_valid", int'(valid), 0);
    chk("mrst_data", int'(data), 0);
    rst = 1'b0;
    ready = 1'b1;
    rx_q.delete();
    e0 = n_ferr; o0 = n_ovr;
    idle(3);
    set_period(19);
    send(8'h42, 1'b1, 20);
    idle(3);
    chk_rx("mrst_next", 8'h42);
    chk("mrst_clean", (n_ferr - e0) + (n_ovr - o0), 0);

    // Reprogram while idle, then a mid-frame write that must not take effect
    set_period(99);
    send(8'h81, 1'b1, 100);
    idle(3);
    chk_rx("prog_81", 8'h81);
    fork
      send(8'hC3, 1'b1, 100);
      begin
        repeat (300) @(negedge clk);
        wr = 1'b1;
        bp_in = 16'd433;
        @(negedge clk);
        wr = 1'b0;
      end
    join
    idle(3);
    chk_rx("prog_midframe", 8'hC3);
    send(8'h96, 1'b1, DEF_P);
    idle(3);
    chk_rx("prog_after", 8'h96);

    // Every byte value at a fast rate
    set_period(7);
    rx_q.delete();
    e0 = n_ferr; o0 = n_ovr;
    for (int v = 0; v < 256; v++) begin
      send(8'(v), 1'b1, 8);
      idle(1);
    end
    idle(3);
    chk("sweep_cnt", rx_q.size(), 256);
    for (int v = 0; v < 256; v++) begin
      if (rx_q.size() == 0) break;
      chk($sformatf("sweep_%0h", v), int'(rx_q.pop_front()), v);
    end
    chk("sweep_errs", (n_ferr - e0) + (n_ovr - o0), 0);

    // Random frames: random period, byte, stop validity
    rx_q.delete();
    e0 = n_ferr;
    exp_err = 0;
    for (int f = 0; f < 40; f++) begin
      int w, p;
      logic [7:0] b;
      logic stop;
      w = $urandom_range(0, 24);
      b = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      set_period(w);
      p = eff_p(w);
      send(b, stop, p);
      idle($urandom_range(1, 4));
      if (stop) exp_q.push_back(b);
      else exp_err++;
    end
    idle(3);
    chk("rand_cnt", rx_q.size(), exp_q.size());
    chk("rand_ferr", n_ferr - e0, exp_err);
    while (exp_q.size() > 0 && rx_q.size() > 0)
      chk("rand_data", int'(rx_q.pop_front()), int'(exp_q.pop_front()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
